data_ram_arbiter: RTL and testbench
===================================

# data_ram_arbiter

Two-requester arbiter and access sequencer in front of the 256×16 data RAM. Port A is the pipeline MEM stage; port B is the program/debug loader. The block picks one request per cycle with round-robin priority and registers the access into a single-cycle RAM slot. It returns registered read data with a valid pulse to the winning port, so the pipeline sees a fixed two-cycle read latency and stalls on lost arbitration.

## Interface
- ADDR_W, 16, address width on both ports and toward RAM
- DATA_W, 16, data width
- clk  in  1  single clock; all state updates on posedge
- reset  in  1  synchronous, active-high
- a_req / b_req  in  1  access request; must hold with stable fields until granted
- a_we / b_we  in  1  1 = write, 0 = read
- a_addr / b_addr  in  ADDR_W  word address
- a_wdata / b_wdata  in  DATA_W  write data
- a_gnt / b_gnt  out  1  request accepted this cycle (combinational)
- a_rvalid / b_rvalid  out  1  one-cycle pulse: response for this port's accepted access
- a_rdata / b_rdata  out  DATA_W  read data; valid only with rvalid and a read
- ram_addr  out  ADDR_W  to RAM DataAddress
- ram_re  out  1  to RAM ReadMem
- ram_we  out  1  to RAM WriteMem
- ram_wdata  out  DATA_W  to RAM DataIn
- ram_rdata  in  DATA_W  from RAM DataOut (combinational read)

## Operation
- States: IDLE (no access slot), ACCESS (slot register holds owner, we, addr, wdata).
- Any cycle, any state: if ≥1 req, exactly one gnt asserts. Accept = req & gnt at the edge.
- Tie (both req): grant the port not granted last. last_owner resets to B, so A wins the first tie.
- Single req: granted immediately, regardless of last_owner. last_owner updates on every accept.
- Accept → next state ACCESS with the slot loaded. No accept → IDLE.
- ACCESS→ACCESS on back-to-back accepts: one access per cycle sustained.
- ACCESS drives ram_addr = slot addr, ram_wdata = slot wdata, ram_re = ~slot we, ram_we = slot we.
- IDLE drives all ram_* outputs to 0.
- End of ACCESS cycle:
  - RAM commits the write on that edge.
  - For a read, ram_rdata is captured into owner's rdata register.
  - owner's rvalid is set for the next cycle, for reads and writes (write ack). For a write, rdata holds its previous value.
- The non-owner's rdata register is never modified.
- ram_rdata is ignored when ram_re = 0; RAM then passes the address through.
- No address range check. Addresses ≥ 256 are RAM-defined behaviour; the arbiter passes them unchanged.

## Timing
- Cycle N: req high, gnt high → accepted.
- Cycle N+1: ACCESS, RAM driven; write commits at the end of N+1.
- Cycle N+2: rvalid = 1 and rdata valid for one cycle.
- Losing port sees gnt = 0 and must hold req and fields. Pipeline stalls on a_req & ~a_gnt.
- Max wait under contention: 1 cycle. Alternation is guaranteed while both hold req.
- Reset values: state IDLE, last_owner B, slot cleared, a/b_rvalid 0, a/b_rdata 0, all ram_* 0.
- While reset = 1: gnt forced 0. ram_we is gated by ~reset, so a write in ACCESS at the reset edge is suppressed.
- An in-flight response is dropped at reset; no rvalid follows reset.
- Deasserting req without gnt is illegal for A. For B it is allowed and simply withdraws the request.

## Structure
- Package mem_arb_pkg holds:
  - state enum {IDLE, ACCESS}
  - owner enum {OWN_A, OWN_B}
  - default width constants ADDR_W = 16, DATA_W = 16
- Sub-module rr_arb2: 2-way round-robin picker.
  - Inputs: req[1:0], last_owner.
  - Outputs: one-hot gnt[1:0].
  - Purely combinational; last_owner register stays in the parent.
- Parent holds the FSM, slot register, response registers and RAM drive logic.

## Test plan
- After reset, A reads addr 0x0010 (mem = 0x1234) → a_gnt in N, ram_re = 1 / ram_addr = 0x0010 in N+1, a_rvalid = 1 and a_rdata = 0x1234 in N+2; b_rvalid stays 0.
- B writes 0x00A5 to addr 0x0020, then A reads 0x0020 the next cycle → b_rvalid in N+2; a_rdata = 0x00A5 in N+3.
- A and B request simultaneously and continuously for 6 cycles → grants A, B, A, B, A, B, with matching rvalid pulses 2 cycles after each grant.
- A requests alone 4 cycles back-to-back (reads 0x01–0x04) → state stays ACCESS, four consecutive a_rvalid pulses with the correct data.
- Reset asserted during an ACCESS write of 0xBEEF to 0x0030 → ram_we = 0 that cycle, mem[0x30] unchanged, no rvalid afterwards, all outputs 0.
- Idle cycles → ram_re = ram_we = 0, ram_addr = 0; RAM pass-through data never appears as rdata.

Source files
------------

// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and default widths for the data RAM arbiter slice.
package mem_arb_pkg;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned DATA_W = 16;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  typedef enum logic {
    OWN_A,
    OWN_B
  } owner_e;

endpackage

// File: rtl/data_ram_arbiter_if.sv
// Requester ports A/B plus the RAM-side drive, bundled for the arbiter.
interface data_ram_arbiter_if #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
);

  logic              a_req;
  logic              a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              a_gnt;
  logic              a_rvalid;
  logic [DATA_W-1:0] a_rdata;

  logic              b_req;
  logic              b_we;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic              b_gnt;
  logic              b_rvalid;
  logic [DATA_W-1:0] b_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_re;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    input  ram_rdata,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output ram_addr, ram_re, ram_we, ram_wdata
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    output ram_rdata,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  ram_addr, ram_re, ram_we, ram_wdata
  );

endinterface

// File: rtl/data_ram_arbiter_rr_arb2.sv
// Two-way round-robin picker: a lone request wins outright, a tie goes to
// the port that did not win last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last_owner,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = '0;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (last_owner == OWN_B) ? 2'b01 : 2'b10;
      default: gnt = '0;
    endcase
  end

endmodule

// File: rtl/data_ram_arbiter.sv
// Arbitrates ports A/B onto the single-cycle data RAM slot and returns a
// registered response (read data or write ack) two cycles after the grant.
module data_ram_arbiter #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  data_ram_arbiter_if.slave   bus
);

  import mem_arb_pkg::*;

  state_e            state_q, state_d;
  owner_e            last_owner_q, last_owner_d;
  owner_e            slot_owner_q, slot_owner_d;
  logic              slot_we_q, slot_we_d;
  logic [ADDR_W-1:0] slot_addr_q, slot_addr_d;
  logic [DATA_W-1:0] slot_wdata_q, slot_wdata_d;
  logic              a_rvalid_q, a_rvalid_d;
  logic              b_rvalid_q, b_rvalid_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;

  logic [1:0] arb_gnt;
  logic [1:0] gnt;
  logic       acc_a;
  logic       acc_b;

  rr_arb2 u_rr_arb2 (
    .req        ({bus.b_req, bus.a_req}),
    .last_owner (last_owner_q),
    .gnt        (arb_gnt)
  );

  always_comb begin
    gnt   = reset ? 2'b00 : arb_gnt;
    acc_a = bus.a_req & gnt[0];
    acc_b = bus.b_req & gnt[1];
  end

  // Next-state: accept loads the slot; the current slot produces the response.
  always_comb begin
    state_d      = IDLE;
    last_owner_d = last_owner_q;
    slot_owner_d = slot_owner_q;
    slot_we_d    = slot_we_q;
    slot_addr_d  = slot_addr_q;
    slot_wdata_d = slot_wdata_q;
    a_rvalid_d   = 1'b0;
    b_rvalid_d   = 1'b0;
    a_rdata_d    = a_rdata_q;
    b_rdata_d    = b_rdata_q;

    if (acc_a) begin
      state_d      = ACCESS;
      last_owner_d = OWN_A;
      slot_owner_d = OWN_A;
      slot_we_d    = bus.a_we;
      slot_addr_d  = bus.a_addr;
      slot_wdata_d = bus.a_wdata;
    end else if (acc_b) begin
      state_d      = ACCESS;
      last_owner_d = OWN_B;
      slot_owner_d = OWN_B;
      slot_we_d    = bus.b_we;
      slot_addr_d  = bus.b_addr;
      slot_wdata_d = bus.b_wdata;
    end

    if (state_q == ACCESS) begin
      if (slot_owner_q == OWN_A) begin
        a_rvalid_d = 1'b1;
        if (!slot_we_q) a_rdata_d = bus.ram_rdata;
      end else begin
        b_rvalid_d = 1'b1;
        if (!slot_we_q) b_rdata_d = bus.ram_rdata;
      end
    end
  end

  always_comb begin
    bus.a_gnt     = gnt[0];
    bus.b_gnt     = gnt[1];
    bus.a_rvalid  = a_rvalid_q;
    bus.b_rvalid  = b_rvalid_q;
    bus.a_rdata   = a_rdata_q;
    bus.b_rdata   = b_rdata_q;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    bus.ram_re    = 1'b0;
    bus.ram_we    = 1'b0;
    if (state_q == ACCESS) begin
      bus.ram_addr  = slot_addr_q;
      bus.ram_wdata = slot_wdata_q;
      bus.ram_re    = ~slot_we_q;
      // A write still in the slot when reset hits must not reach the RAM.
      bus.ram_we    = slot_we_q & ~reset;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_owner_q <= OWN_B;
      slot_owner_q <= OWN_A;
      slot_we_q    <= 1'b0;
      slot_addr_q  <= '0;
      slot_wdata_q <= '0;
      a_rvalid_q   <= 1'b0;
      b_rvalid_q   <= 1'b0;
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      slot_owner_q <= slot_owner_d;
      slot_we_q    <= slot_we_d;
      slot_addr_q  <= slot_addr_d;
      slot_wdata_q <= slot_wdata_d;
      a_rvalid_q   <= a_rvalid_d;
      b_rvalid_q   <= b_rvalid_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed plus randomized bench for data_ram_arbiter against a transaction
// model: each accepted request is scheduled for RAM at t+1 and response at t+2.
module tb_data_ram_arbiter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  data_ram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  data_ram_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // 256x16 RAM: combinational read, address pass-through when not reading.
  logic [15:0] ram_mem [256];
  always @(posedge clk) if (bus.ram_we) ram_mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
  assign bus.ram_rdata = bus.ram_re ? ram_mem[bus.ram_addr[7:0]] : bus.ram_addr;

  typedef struct {
    int unsigned t;
    logic        port;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } txn_t;

  txn_t        q[$];
  logic [15:0] model_mem [256];
  logic [15:0] exp_rdata [2];
  logic        last_b;
  logic        a_hold, b_hold;
  int unsigned cyc, n_vec, n_bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_a(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
    bus.a_req = req; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
  endtask

  task automatic set_b(input logic req, input logic we, input logic [15:0] addr, input logic [15:0] wd);
    bus.b_req = req; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
  endtask

  // Inputs are already driven (posedge+1); check mid-cycle, then advance model.
  task automatic step();
    logic ga, gb, exp_re, exp_we, exp_av, exp_bv;
    logic [15:0] exp_addr, exp_wd;
    #3;
    ga = 1'b0; gb = 1'b0;
    if (!reset) begin
      if (bus.a_req && bus.b_req) begin ga = last_b; gb = !last_b; end
      else begin ga = bus.a_req; gb = bus.b_req; end
    end
    exp_re = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_wd = '0; exp_av = 1'b0; exp_bv = 1'b0;
    foreach (q[i]) begin
      if (q[i].t + 1 == cyc) begin
        exp_addr = q[i].addr; exp_wd = q[i].wdata;
        exp_re = !q[i].we; exp_we = q[i].we && !reset;
      end
      if (q[i].t + 2 == cyc) begin
        if (q[i].port) exp_bv = 1'b1; else exp_av = 1'b1;
      end
    end
    check("a_gnt", bus.a_gnt, ga);
    check("b_gnt", bus.b_gnt, gb);
    check("a_rvalid", bus.a_rvalid, exp_av);
    check("b_rvalid", bus.b_rvalid, exp_bv);
    check("a_rdata", bus.a_rdata, exp_rdata[0]);
    check("b_rdata", bus.b_rdata, exp_rdata[1]);
    check("ram_addr", bus.ram_addr, exp_addr);
    check("ram_wdata", bus.ram_wdata, exp_wd);
    check("ram_re", bus.ram_re, exp_re);
    check("ram_we", bus.ram_we, exp_we);

    @(posedge clk); #1;
    if (reset) begin
      q.delete();
      exp_rdata[0] = '0; exp_rdata[1] = '0;
      last_b = 1'b1;
    end else begin
      foreach (q[i]) begin
        if (q[i].t + 1 == cyc) begin
          if (q[i].we) model_mem[q[i].addr[7:0]] = q[i].wdata;
          else exp_rdata[q[i].port] = model_mem[q[i].addr[7:0]];
        end
      end
      if (ga) begin
        q.push_back('{t: cyc, port: 1'b0, we: bus.a_we, addr: bus.a_addr, wdata: bus.a_wdata});
        last_b = 1'b0;
      end else if (gb) begin
        q.push_back('{t: cyc, port: 1'b1, we: bus.b_we, addr: bus.b_addr, wdata: bus.b_wdata});
        last_b = 1'b1;
      end
      while (q.size() > 0 && q[0].t + 2 <= cyc) void'(q.pop_front());
    end
    a_hold = bus.a_req && !ga;
    b_hold = bus.b_req && !gb;
    cyc++;
  endtask

  function automatic logic [15:0] rand_addr();
    if ($urandom_range(0, 9) == 0) return 16'($urandom);
    return 16'($urandom_range(0, 255));
  endfunction

  initial begin
    n_vec = 0; n_bad = 0; cyc = 0;
    last_b = 1'b1; a_hold = 1'b0; b_hold = 1'b0;
    exp_rdata[0] = '0; exp_rdata[1] = '0;
    for (int i = 0; i < 256; i++) begin
      ram_mem[i]   = 16'(i * 16'h0101) ^ 16'h5A00;
      model_mem[i] = 16'(i * 16'h0101) ^ 16'h5A00;
    end
    ram_mem[8'h10] = 16'h1234; model_mem[8'h10] = 16'h1234;

    reset = 1'b1;
    set_a(1'b0, 1'b0, '0, '0);
    set_b(1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    step(); step();
    reset = 1'b0;
    step();

    // A reads 0x0010
    set_a(1'b1, 1'b0, 16'h0010, '0); step();
    set_a(1'b0, 1'b0, '0, '0); step(); step(); step();
    check("a_rdata_0x10", bus.a_rdata, 32'h1234);

    // B writes 0x00A5 to 0x0020, A reads it back next cycle
    set_b(1'b1, 1'b1, 16'h0020, 16'h00A5); step();
    set_b(1'b0, 1'b0, '0, '0);
    set_a(1'b1, 1'b0, 16'h0020, '0); step();
    set_a(1'b0, 1'b0, '0, '0); step(); step(); step();
    check("a_rdata_0x20", bus.a_rdata, 32'h00A5);

    // Reset reapplied so the first tie below goes to A
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (!a_hold) set_a(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom));
      if (!b_hold) set_b(1'b1, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 255)), 16'($urandom));
      step();
    end
    set_a(1'b0, 1'b0, '0, '0); set_b(1'b0, 1'b0, '0, '0);
    step(); step(); step();

    // A back-to-back reads 0x01..0x04
    for (int i = 1; i <= 4; i++) begin
      set_a(1'b1, 1'b0, 16'(i), '0); step();
    end
    set_a(1'b0, 1'b0, '0, '0); step(); step(); step();

    // Reset lands on the ACCESS cycle of a write
    set_b(1'b1, 1'b1, 16'h0030, 16'hBEEF); step();
    set_b(1'b0, 1'b0, '0, '0);
    reset = 1'b1; step();
    reset = 1'b0; step(); step(); step();
    check("mem_0x30_kept", ram_mem[8'h30], 32'h6A30);

    // Random traffic with occasional resets
    for (int n = 0; n < 600; n++) begin
      reset = ($urandom_range(0, 60) == 0);
      if (!a_hold) set_a(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
      if (!b_hold || $urandom_range(0, 3) == 0)
        set_b(1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), rand_addr(), 16'($urandom));
      step();
    end
    reset = 1'b0;
    set_a(1'b0, 1'b0, '0, '0); set_b(1'b0, 1'b0, '0, '0);
    step(); step(); step();
    for (int i = 0; i < 256; i += 17)
      check("mem_final", ram_mem[i], model_mem[i]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
